// File: rtl/dm_arbiter_pkg.sv
// Shared types for the DM arbiter: FSM state encoding, port ids and a port-select helper.
// The DM_ARB_CPU_PRIO_EN macro (fixed CPU priority) is consumed by dm_arb_rr.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic ARB_CPU = 1'b0;
  localparam logic ARB_DMA = 1'b1;

  // One-hot per-port strobe for a given port id.
  function automatic logic [1:0] port_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dm_arb_rr.sv
// Combinational 2-way picker for the DM arbiter.
// Round-robin by default; DM_ARB_CPU_PRIO_EN makes port 0 win every contest.
module dm_arb_rr
  import dm_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_id,
  output logic grant_valid
);

`ifdef DM_ARB_CPU_PRIO_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Winner selection from the current requests and the last served port.
  always_comb begin
    grant_valid = req0 | req1;
    grant_id    = ARB_CPU;
    if (req0 && req1) begin
`ifdef DM_ARB_CPU_PRIO_EN
      grant_id = ARB_CPU;
`else
      grant_id = ~last_grant;
`endif
    end else if (req1) begin
      grant_id = ARB_DMA;
    end else begin
      grant_id = ARB_CPU;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single-ported data memory between the CPU (port 0) and DMA/debug loader (port 1).
// Build with DM_ARB_CPU_PRIO_EN defined for fixed CPU priority instead of round-robin.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          dm_memwr,
  input  logic [DW-1:0] dm_rdata,
  output logic          busy,
  output logic          last_grant
);

  logic          grant_id_s;
  logic          grant_valid_s;
  logic          sel_we_s;
  logic          sel_inr_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  arb_state_e    state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          inr_q, inr_d;
  logic [AW-1:0] dm_addr_q, dm_addr_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;
  logic          dm_memwr_q, dm_memwr_d;
  logic [1:0]    ack_q, ack_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          last_grant_q, last_grant_d;
  logic          busy_q, busy_d;

  dm_arb_rr u_rr (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_q),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  assign sel_we_s    = (grant_id_s == ARB_DMA) ? we1    : we0;
  assign sel_addr_s  = (grant_id_s == ARB_DMA) ? addr1  : addr0;
  assign sel_wdata_s = (grant_id_s == ARB_DMA) ? wdata1 : wdata0;
  // Byte-address compare; the low two bits never matter for a word-sized DM.
  assign sel_inr_s   = (sel_addr_s < AW'(MEM_BYTES));

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    we_d         = we_q;
    inr_d        = inr_q;
    dm_addr_d    = '0;
    dm_wdata_d   = '0;
    dm_memwr_d   = 1'b0;
    ack_d        = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_valid_s) begin
          state_d    = ARB_ACCESS;
          id_d       = grant_id_s;
          we_d       = sel_we_s;
          inr_d      = sel_inr_s;
          dm_addr_d  = sel_addr_s;
          dm_wdata_d = sel_wdata_s;
          dm_memwr_d = sel_we_s & sel_inr_s;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ACCESS: begin
        state_d = ARB_RESP;
        ack_d   = port_onehot(id_q);
        err_d   = inr_q ? 2'b00 : port_onehot(id_q);
        // DM read data is combinational, so it is valid on the edge that ends ACCESS.
        if (!we_q) begin
          if (id_q == ARB_DMA) begin
            rdata1_d = inr_q ? dm_rdata : '0;
          end else begin
            rdata0_d = inr_q ? dm_rdata : '0;
          end
        end else begin
          rdata0_d = rdata0_q;
        end
      end
      ARB_RESP: begin
        state_d      = ARB_IDLE;
        last_grant_d = id_q;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  // State and registered outputs; reset clears everything at once, including dm_memwr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      id_q         <= ARB_CPU;
      we_q         <= 1'b0;
      inr_q        <= 1'b0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      dm_memwr_q   <= 1'b0;
      ack_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      last_grant_q <= ARB_DMA;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      we_q         <= we_d;
      inr_q        <= inr_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_memwr_q   <= dm_memwr_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_memwr   = dm_memwr_q;
  assign busy       = busy_q;
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed scenarios then random two-port traffic,
// all checked cycle by cycle against a transaction-level model with a reference memory.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_memwr, busy, last_grant;

  logic [31:0] mem [0:1023];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_memwr(dm_memwr),
    .dm_rdata(dm_rdata), .busy(busy), .last_grant(last_grant)
  );

  // Data memory: combinational read, write on posedge.
  assign dm_rdata = mem[dm_addr[11:2]];
  always @(posedge clk) begin
    if (dm_memwr) mem[dm_addr[11:2]] <= dm_wdata;
  end

  // Transaction-level model state.
  int          t = 0, free_at = 0, g = 0, grants = 0;
  bit          pend = 1'b0, gp = 1'b0, gwe = 1'b0, m_last = 1'b1;
  logic [31:0] gaddr = 32'd0, gwdata = 32'd0;
  logic [31:0] m_rdata [2];
  logic [31:0] ref_mem [1024];
  bit          ack_now [2];
  int          memwr_cnt = 0, busy_cnt = 0, last_ack_t = 0;
  bit          last_err = 1'b0;
  int          order_q [$];

  function automatic logic [31:0] pattern(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend       = 1'b0;
    m_last     = 1'b1;
    m_rdata[0] = 32'd0;
    m_rdata[1] = 32'd0;
    free_at    = 0;
  endtask

  // One clock: advance the model at the posedge, compare every output at the negedge.
  task automatic cycle();
    bit acc, rsp, inr;
    @(posedge clk);
    t++;
    if (pend && t == g + 1) begin
      if (gaddr < 32'd4096) begin
        if (gwe) ref_mem[gaddr[11:2]] = gwdata;
        else     m_rdata[gp] = ref_mem[gaddr[11:2]];
      end else if (!gwe) begin
        m_rdata[gp] = 32'd0;
      end
    end
    if (pend && t == g + 2) begin
      m_last = gp;
      pend   = 1'b0;
    end
    if (!pend && t >= free_at && (req0 || req1)) begin
`ifdef DM_ARB_CPU_PRIO_EN
      if (req0 && req1) gp = 1'b0; else gp = req1;
`else
      if (req0 && req1) gp = !m_last; else gp = req1;
`endif
      pend    = 1'b1;
      g       = t;
      free_at = t + 3;
      grants++;
      gwe    = gp ? we1 : we0;
      gaddr  = gp ? addr1 : addr0;
      gwdata = gp ? wdata1 : wdata0;
    end
    @(negedge clk);
    acc = pend && (t == g);
    rsp = pend && (t == g + 1);
    inr = (gaddr < 32'd4096);
    chk1("ack0", ack0, rsp && !gp);
    chk1("ack1", ack1, rsp && gp);
    chk1("err0", err0, rsp && !gp && !inr);
    chk1("err1", err1, rsp && gp && !inr);
    chk1("dm_memwr", dm_memwr, acc && gwe && inr);
    chk("dm_addr", dm_addr, acc ? gaddr : 32'd0);
    chk("dm_wdata", dm_wdata, acc ? gwdata : 32'd0);
    chk1("busy", busy, acc || rsp);
    chk1("last_grant", last_grant, m_last);
    chk("rdata0", rdata0, m_rdata[0]);
    chk("rdata1", rdata1, m_rdata[1]);
    ack_now[0] = ack0;
    ack_now[1] = ack1;
    if (dm_memwr) memwr_cnt++;
    if (busy) busy_cnt++;
    if (ack0) order_q.push_back(0);
    if (ack1) order_q.push_back(1);
    if (ack0 || ack1) begin
      last_ack_t = t;
      last_err   = err0 | err1;
    end
  endtask

  // Run until nacks acks are seen; a non-holding requester drops req the cycle after its ack.
  task automatic run(input int nacks, input bit hold0, input bit hold1, input int maxc);
    int seen = 0;
    int c    = 0;
    bit d0 = 1'b0, d1 = 1'b0;
    while (seen < nacks && c < maxc) begin
      cycle();
      c++;
      if (d0) begin req0 = 1'b0; d0 = 1'b0; end
      if (d1) begin req1 = 1'b0; d1 = 1'b0; end
      if (ack_now[0]) begin seen++; if (!hold0) d0 = 1'b1; end
      if (ack_now[1]) begin seen++; if (!hold1) d1 = 1'b1; end
    end
    chk1("ack_within_budget", seen >= nacks, 1'b1);
    if (d0 || d1) begin
      cycle();
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
    end
  endtask

  task automatic serve(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d);
    int ts;
    if (p) begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    ts        = t;
    memwr_cnt = 0;
    order_q.delete();
    run(1, 1'b0, 1'b0, 10);
    chk("latency", 32'(last_ack_t - ts), 32'd2);
  endtask

  task automatic new_txn(input int p);
    logic        w;
    logic [31:0] a, d;
    w = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) a = 32'h0000_1000 + 32'($urandom_range(0, 255));
    else                           a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
    d = $urandom;
    if (p == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else        begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
  endtask

  initial begin
    bit outst [2];
    bit drop  [2];
    int gap   [2];
    int grants_before;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = pattern(i);
      ref_mem[i] = pattern(i);
    end
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
    model_reset();

    // 1: reset held three cycles, then released.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_last_grant", last_grant, 1'b1);
    chk1("rst_memwr", dm_memwr, 1'b0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    reset = 1'b1;
    repeat (2) cycle();

    // 2: store then load on port 0.
    serve(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("t2_memwr_cnt", memwr_cnt, 32'd1);
    serve(1'b0, 1'b0, 32'h10, 32'd0);
    chk("t2_rdata0", rdata0, 32'hDEAD_BEEF);

    // 3: contention; port 1 served first so port 0 is next in line.
    serve(1'b1, 1'b0, 32'h20, 32'd0);
    chk("t3_rdata1", rdata1, 32'hA500_0008);
    we0 = 1'b0; addr0 = 32'h10; we1 = 1'b0; addr1 = 32'h24;
    req0 = 1'b1; req1 = 1'b1;
    order_q.delete();
    run(2, 1'b0, 1'b0, 20);
    chk("t3_pair_n", order_q.size(), 32'd2);
    if (order_q.size() == 2) begin
      chk("t3_pair_0", order_q[0], 32'd0);
      chk("t3_pair_1", order_q[1], 32'd1);
    end
    req0 = 1'b1; req1 = 1'b1;
    order_q.delete();
    run(4, 1'b1, 1'b1, 40);
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_hold_n", order_q.size(), 32'd4);
    if (order_q.size() == 4) begin
`ifdef DM_ARB_CPU_PRIO_EN
      chk("t3_hold_0", order_q[0], 32'd0);
      chk("t3_hold_1", order_q[1], 32'd0);
      chk("t3_hold_2", order_q[2], 32'd0);
      chk("t3_hold_3", order_q[3], 32'd0);
`else
      chk("t3_hold_0", order_q[0], 32'd0);
      chk("t3_hold_1", order_q[1], 32'd1);
      chk("t3_hold_2", order_q[2], 32'd0);
      chk("t3_hold_3", order_q[3], 32'd1);
`endif
    end
    repeat (2) cycle();

    // 4: out-of-range store and load on port 1.
    serve(1'b1, 1'b1, 32'h1000, 32'h1234_5678);
    chk("t4_memwr_cnt", memwr_cnt, 32'd0);
    chk1("t4_err1", last_err, 1'b1);
    serve(1'b1, 1'b0, 32'h1000, 32'd0);
    chk1("t4_err1_ld", last_err, 1'b1);
    chk("t4_rdata1", rdata1, 32'd0);

    // 5: reset asserted while a store is in ACCESS.
    we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h0BAD_F00D; req0 = 1'b1;
    cycle();
    chk1("t5_memwr_pre", dm_memwr, 1'b1);
    reset = 1'b0;
    #1;
    chk1("t5_memwr_drop", dm_memwr, 1'b0);
    chk1("t5_busy_drop", busy, 1'b0);
    chk1("t5_no_ack", ack0, 1'b0);
    model_reset();
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle();
    serve(1'b0, 1'b0, 32'h40, 32'd0);
    chk("t5_rdata0", rdata0, 32'hA500_0010);

    // 6: request withdrawn right after the grant latch.
    we0 = 1'b0; addr0 = 32'h10; req0 = 1'b1;
    grants_before = grants;
    cycle();
    req0 = 1'b0;
    run(1, 1'b0, 1'b0, 10);
    busy_cnt = 0;
    repeat (4) cycle();
    chk("t6_extra_busy", busy_cnt, 32'd0);
    chk("t6_grants", grants - grants_before, 32'd1);
    chk("t6_rdata0", rdata0, 32'hDEAD_BEEF);

    // Random two-port traffic.
    for (int p = 0; p < 2; p++) begin
      outst[p] = 1'b0; drop[p] = 1'b0; gap[p] = 0;
    end
    for (int n = 0; n < 600; n++) begin
      cycle();
      for (int p = 0; p < 2; p++) begin
        if (drop[p]) begin
          if (p == 0) req0 = 1'b0; else req1 = 1'b0;
          drop[p]  = 1'b0;
          outst[p] = 1'b0;
          gap[p]   = int'($urandom_range(0, 2));
        end else if (ack_now[p]) begin
          drop[p] = 1'b1;
        end else if (!outst[p]) begin
          if (gap[p] > 0) gap[p]--;
          else begin
            new_txn(p);
            outst[p] = 1'b1;
          end
        end else begin
          outst[p] = 1'b1;
        end
      end
      if (pend && t == g) begin
        if (gp) begin addr1 = $urandom; wdata1 = $urandom; end
        else    begin addr0 = $urandom; wdata0 = $urandom; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
